// File: rtl/demux16_sched.sv
// demux16_sched: one-word demux with round-robin grant to 16 channels.
// Ports: clk/rst_n, in_* upstream handshake, ch_en/ch_ready per channel,
//        out_valid (one-hot), out_data, sel (grant index), done (pulse).
module demux16_sched #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    input  logic [15:0]   ch_en,
    input  logic [15:0]   ch_ready,
    output logic [15:0]   out_valid,
    output logic [DW-1:0] out_data,
    output logic [3:0]    sel,
    output logic          done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARB   = 2'd1;
    localparam logic [1:0] DRIVE = 2'd2;

    logic [1:0]    state;
    logic [3:0]    last_sel;
    logic [3:0]    grant;
    logic [3:0]    idx;
    logic [DW-1:0] hold;
    logic          in_drive;

    assign in_drive = (state == DRIVE);
    assign in_ready = (state == IDLE) && (|ch_en);
    assign done     = in_drive && ch_ready[sel];
    assign out_data = hold;

    always_comb begin
        out_valid = '0;
        if (in_drive) begin
            out_valid = 16'd1 << sel;
        end
    end

    // Scan last_sel+16 down to last_sel+1 so the nearest enabled
    // channel above last_sel overwrites farther ones; k=16 wraps to
    // last_sel itself, which therefore has the lowest priority.
    always_comb begin
        grant = last_sel;
        idx   = last_sel;
        for (int k = 16; k >= 1; k--) begin
            idx = last_sel + 4'(k);
            if (ch_en[idx]) begin
                grant = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 4'd0;
            last_sel <= 4'd15;
            hold     <= '0;
        end else begin
            unique case (1'b1)
                (state == IDLE): begin
                    if (in_valid && in_ready) begin
                        hold  <= in_data;
                        state <= ARB;
                    end
                end
                (state == ARB): begin
                    // No enabled channel: keep the word and retry.
                    if (|ch_en) begin
                        sel   <= grant;
                        state <= DRIVE;
                    end
                end
                (state == DRIVE): begin
                    if (ch_ready[sel]) begin
                        last_sel <= sel;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
